sseg_scan_driver: RTL and testbench

- Downstream consumer of the single-cycle datapath's ALU result. Replaces the static one-digit seven-segment hookup with a time-multiplexed 4-digit hex display driver.
- Captures a 16-bit value plus decimal-point mask on a load strobe.
- Buffers the capture so a visible update happens only at a frame boundary, so no digit ever shows a torn value.
- Scans the four digits with a prescaled refresh counter; optional leading-zero blanking.

---
 rtl/sseg_scan_driver_if.sv | 24 ++
 rtl/sseg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_sseg_scan_driver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_driver_if.sv
// Bundle between the datapath side and the seven-segment scan driver.
// The datapath (master) presents the value, the decimal-point mask, the load
// strobe and the blanking select. The driver (slave) returns the active-low
// panel drive and the frame pulse.
interface sseg_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        load;
  logic        lz_blank;
  logic [6:0]  sseg_cathode;
  logic        sseg_dp;
  logic [3:0]  sseg_anode;
  logic        frame_done;

  modport master (
    output value, dp_mask, load, lz_blank,
    input  sseg_cathode, sseg_dp, sseg_anode, frame_done
  );

  modport slave (
    input  value, dp_mask, load, lz_blank,
    output sseg_cathode, sseg_dp, sseg_anode, frame_done
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit hex display driver.
// A captured value is held in a shadow register. It is promoted to the
// visible register only at the end of a full scan, so a digit never shows
// part of an old value and part of a new one.
module sseg_scan_driver #(
  parameter int DIGIT_TICKS = 100000,
  parameter int CNT_W       = 17
) (
  input  logic           clk,
  input  logic           reset,
  sseg_scan_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIGIT_TICKS - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             tick;
  logic             boundary;

  logic [15:0]      shadow_val;
  logic [3:0]       shadow_dp;
  logic             pending;
  logic [15:0]      disp_reg;
  logic [3:0]       disp_dp;

  logic [3:0]       nib;
  logic [6:0]       seg;
  logic             lead_zero;
  logic             blank;
  logic [3:0]       anode_next;
  logic [6:0]       cathode_next;
  logic             dp_next;

  assign tick     = (cnt == LAST_COUNT);
  assign boundary = tick && (idx == 2'd3);

  // Prescaler: sets how long each digit stays lit before the scan moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Digit index: steps through digits 0..3 once per prescaler wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     idx <= 2'd0;
    else if (tick) idx <= idx + 2'd1;
  end

  // Capture and frame-aligned promotion. A load on the boundary cycle goes
  // straight to the visible register, so nothing is left pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_reg   <= '0;
      disp_dp    <= '0;
    end else begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_mask;
      end
      if (boundary) begin
        if (bus.load) begin
          disp_reg <= bus.value;
          disp_dp  <= bus.dp_mask;
        end else if (pending) begin
          disp_reg <= shadow_val;
          disp_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // Select the current nibble and decide whether it is a leading zero.
  always_comb begin
    nib       = disp_reg[{idx, 2'b00} +: 4];
    lead_zero = 1'b0;
    unique case (idx)
      2'd0: lead_zero = 1'b0;
      2'd1: lead_zero = (disp_reg[15:4]  == 12'd0);
      2'd2: lead_zero = (disp_reg[15:8]  == 8'd0);
      2'd3: lead_zero = (disp_reg[15:12] == 4'd0);
    endcase
    blank = bus.lz_blank && lead_zero;
  end

  // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
  always_comb begin
    seg = 7'h7F;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

  // Next panel drive. A blanked digit turns off its anode, segments and point.
  always_comb begin
    anode_next   = ~(4'b0001 << idx);
    cathode_next = seg;
    dp_next      = ~disp_dp[idx];
    if (blank) begin
      anode_next   = 4'b1111;
      cathode_next = 7'h7F;
      dp_next      = 1'b1;
    end
  end

  // Output register: keeps the panel drive glitch-free and marks frame ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sseg_anode   <= 4'b1111;
      bus.sseg_cathode <= 7'h7F;
      bus.sseg_dp      <= 1'b1;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.sseg_anode   <= anode_next;
      bus.sseg_cathode <= cathode_next;
      bus.sseg_dp      <= dp_next;
      bus.frame_done   <= boundary;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with DIGIT_TICKS=4, giving a frame of
// 16 cycles. A vector table covers per-digit decoding and blanking.
// Hand-written sequences cover reset, tear-free update, load on the
// boundary and asynchronous reset during a scan.
module tb_sseg_scan_driver;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  cath;
    logic        dpo;
  } vec_t;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   tot_cnt;
  vec_t vecs[26];

  sseg_scan_driver_if bus();

  sseg_scan_driver #(.DIGIT_TICKS(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then park on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_panel(input string name, input logic [3:0] an, input logic [6:0] cath, input logic dpo);
    check_output({name, ".anode"},   {12'd0, bus.sseg_anode},  {12'd0, an});
    check_output({name, ".cathode"}, {9'd0, bus.sseg_cathode}, {9'd0, cath});
    check_output({name, ".dp"},      {15'd0, bus.sseg_dp},     {15'd0, dpo});
  endtask

  // Step until frame_done is seen (bounded), leaving frame_done high.
  task automatic wait_frame_done(output int steps);
    steps = 0;
    while (bus.frame_done !== 1'b1 && steps < 40) begin
      step();
      steps++;
    end
    if (bus.frame_done !== 1'b1) begin
      tot_cnt++;
      $display("[TB] FAIL frame_done_timeout: got %b after %0d cycles, expected 1", bus.frame_done, steps);
    end
  endtask

  // Pulse load for one cycle, then move to digit 0 of the frame showing it.
  task automatic apply_stimulus(input logic [15:0] value, input logic [3:0] dp, input logic lz);
    int n;
    bus.lz_blank = lz;
    bus.value    = value;
    bus.dp_mask  = dp;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
    wait_frame_done(n);
    step();
  endtask

  task automatic pulse_load(input logic [15:0] value);
    bus.value = value;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  initial begin
    int n;
    pass_cnt = 0;
    tot_cnt  = 0;

    vecs[0]  = '{16'h12AF, 4'b0100, 1'b0, 0, 4'b1110, 7'h0E, 1'b1};
    vecs[1]  = '{16'h12AF, 4'b0100, 1'b0, 1, 4'b1101, 7'h08, 1'b1};
    vecs[2]  = '{16'h12AF, 4'b0100, 1'b0, 2, 4'b1011, 7'h24, 1'b0};
    vecs[3]  = '{16'h12AF, 4'b0100, 1'b0, 3, 4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h0005, 4'b0000, 1'b1, 0, 4'b1110, 7'h12, 1'b1};
    vecs[5]  = '{16'h0005, 4'b0000, 1'b1, 1, 4'b1111, 7'h7F, 1'b1};
    vecs[6]  = '{16'h0005, 4'b1111, 1'b1, 2, 4'b1111, 7'h7F, 1'b1};
    vecs[7]  = '{16'h0005, 4'b1111, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[8]  = '{16'h0005, 4'b1111, 1'b1, 0, 4'b1110, 7'h12, 1'b0};
    vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vecs[10] = '{16'h0000, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[11] = '{16'h0500, 4'b0000, 1'b1, 1, 4'b1101, 7'h40, 1'b1};
    vecs[12] = '{16'h0500, 4'b0000, 1'b1, 2, 4'b1011, 7'h12, 1'b1};
    vecs[13] = '{16'h0500, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[14] = '{16'h0500, 4'b0000, 1'b0, 3, 4'b0111, 7'h40, 1'b1};
    vecs[15] = '{16'h9E6D, 4'b0000, 1'b0, 0, 4'b1110, 7'h21, 1'b1};
    vecs[16] = '{16'h9E6D, 4'b1000, 1'b0, 1, 4'b1101, 7'h02, 1'b1};
    vecs[17] = '{16'h9E6D, 4'b1000, 1'b0, 2, 4'b1011, 7'h06, 1'b1};
    vecs[18] = '{16'h9E6D, 4'b1000, 1'b0, 3, 4'b0111, 7'h10, 1'b0};
    vecs[19] = '{16'h34C7, 4'b0001, 1'b0, 0, 4'b1110, 7'h78, 1'b0};
    vecs[20] = '{16'h34C7, 4'b0000, 1'b0, 1, 4'b1101, 7'h46, 1'b1};
    vecs[21] = '{16'h34C7, 4'b0000, 1'b0, 2, 4'b1011, 7'h19, 1'b1};
    vecs[22] = '{16'h34C7, 4'b0000, 1'b0, 3, 4'b0111, 7'h30, 1'b1};
    vecs[23] = '{16'h8B00, 4'b0000, 1'b1, 2, 4'b1011, 7'h03, 1'b1};
    vecs[24] = '{16'h8B00, 4'b0000, 1'b1, 1, 4'b1101, 7'h40, 1'b1};
    vecs[25] = '{16'h8B00, 4'b0000, 1'b0, 3, 4'b0111, 7'h00, 1'b1};

    bus.value    = 16'h0000;
    bus.dp_mask  = 4'b0000;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;

    // Reset applies before any clock edge and holds across edges.
    reset = 1'b1;
    #1;
    check_panel("reset_async", 4'b1111, 7'h7F, 1'b1);
    check_output("reset_async.frame_done", {15'd0, bus.frame_done}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check_panel("reset_held", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0;
    step();
    check_panel("reset_release", 4'b1110, 7'h40, 1'b1);
    check_output("reset_release.frame_done", {15'd0, bus.frame_done}, 16'd0);

    // Table: load each vector, wait for its frame, then inspect one digit.
    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i].value, vecs[i].dp, vecs[i].lz);
      repeat (4 * vecs[i].digit) step();
      check_panel($sformatf("vec%0d", i), vecs[i].an, vecs[i].cath, vecs[i].dpo);
    end

    // Tear-free update: mid-frame loads stay hidden until the next frame.
    apply_stimulus(16'h3333, 4'b0000, 1'b0);
    repeat (4) step();
    check_panel("tear.d1_old", 4'b1101, 7'h30, 1'b1);
    pulse_load(16'h1111);
    repeat (3) step();
    check_panel("tear.d2_old", 4'b1011, 7'h30, 1'b1);
    pulse_load(16'h2222);
    repeat (3) step();
    check_panel("tear.d3_old", 4'b0111, 7'h30, 1'b1);
    wait_frame_done(n);
    check_output("tear.fd_delay", 16'(n), 16'd3);
    step();
    check_output("tear.fd_width", {15'd0, bus.frame_done}, 16'd0);
    for (int d = 0; d < 4; d++) begin
      if (d != 0) repeat (4) step();
      check_panel($sformatf("tear.new_d%0d", d), ~(4'b0001 << d), 7'h24, 1'b1);
    end
    wait_frame_done(n);
    step();
    n = 1;
    while (bus.frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_output("frame_period", 16'(n), 16'd16);

    // Load on the boundary cycle: shown in the very next frame, nothing pending.
    repeat (15) step();
    pulse_load(16'h9999);
    check_output("bnd.pending", {15'd0, dut.pending}, 16'd0);
    check_output("bnd.frame_done", {15'd0, bus.frame_done}, 16'd1);
    step();
    for (int d = 0; d < 4; d++) begin
      if (d != 0) repeat (4) step();
      check_panel($sformatf("bnd.d%0d", d), ~(4'b0001 << d), 7'h10, 1'b1);
    end

    // Asynchronous reset while digit 2 is lit.
    repeat (12) step();
    check_panel("mid.pre_d2", 4'b1011, 7'h10, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_panel("mid.async", 4'b1111, 7'h7F, 1'b1);
    check_output("mid.disp_reg", dut.disp_reg, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_panel("mid.restart_d0", 4'b1110, 7'h40, 1'b1);
    repeat (4) step();
    check_panel("mid.restart_d1", 4'b1101, 7'h40, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
